inst_prefetch_queue: RTL and testbench
======================================

Name: inst_prefetch_queue

Overview:
- Instruction prefetch queue sitting upstream of the pipeline's IF stage.
- Its core side supplies the core's inst_i; its other side drives a pipelined, variable-latency instruction memory port (req/gnt, in-order rvalid).
- It prefetches sequential words ahead of the PC, flushes on any PC redirect (branch or reset), and reports inst_valid_o so IF can hold the PC on a miss.

Parameters:
DEPTH, 4, queue entries; also the cap on occupancy + in-flight + pending-drop requests; power of 2, ≥2.
RESET_ADDR, 32'h0000_0000, head/fetch address after reset.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
inst_addr_i  input  32  PC from IF (core inst_addr_o).
inst_ce_i  input  1  core fetch enable (core inst_ce_o); 0 → no requests, no output valid.
inst_ack_i  input  1  IF consumes the current instruction this cycle (PC advances).
inst_o  output  32  instruction for inst_addr_i; 0 when inst_valid_o=0.
inst_valid_o  output  1  inst_o valid for inst_addr_i.
mem_req_o  output  1  fetch request.
mem_addr_o  output  32  word address of request.
mem_gnt_i  input  1  request accepted this cycle.
mem_rvalid_i  input  1  response data valid; one per grant, in order, ≥1 cycle after grant.
mem_rdata_i  input  32  response word.

Behaviour:
- State:
  - FIFO of DEPTH words: rd_ptr, wr_ptr, count 0..DEPTH.
  - head_addr: address of the FIFO head.
  - fetch_addr: next address to request.
  - inflight: granted, not yet returned, to be kept.
  - drop_cnt: granted, to be discarded.
- Reset (rst=0, async):
  - count=inflight=drop_cnt=0; head_addr=fetch_addr=RESET_ADDR.
  - All outputs 0, except mem_addr_o = RESET_ADDR.
- redirect = inst_ce_i && (inst_addr_i != head_addr). This is combinational.
- hit = inst_ce_i && !redirect && count!=0.
  - inst_valid_o = hit.
  - inst_o = hit ? FIFO[rd_ptr] : 0.
- mem_req_o = inst_ce_i && !redirect && (count + inflight + drop_cnt < DEPTH).
  - mem_addr_o = fetch_addr.
  - Request held until mem_gnt_i; address stable while mem_req_o is high.
- Grant (mem_req_o && mem_gnt_i): fetch_addr += 4 (mod 2^32); inflight += 1.
- Response (mem_rvalid_i):
  - If drop_cnt != 0: drop_cnt -= 1, data discarded.
  - Else: write FIFO[wr_ptr], count += 1, inflight -= 1.
  - Drop has priority; the word is visible at inst_o the next cycle (no bypass).
- Pop: hit && inst_ack_i → rd_ptr++, count -= 1, head_addr += 4. inst_ack_i without hit is ignored.
- Redirect edge:
  - count=0, pointers reset.
  - head_addr = fetch_addr = inst_addr_i.
  - drop_cnt = drop_cnt + inflight, plus 1 if a response arrives this cycle that would be kept... A response arriving this cycle is always discarded, so the rule is: drop_cnt_next = drop_cnt + inflight − (mem_rvalid_i ? 1 : 0); inflight=0.
  - No request and no pop in a redirect cycle.
- Simultaneous events in one cycle: grant, response and pop all net correctly. count and inflight never exceed DEPTH; count + inflight + drop_cnt ≤ DEPTH always.
- Minimum miss latency:
  - Redirect seen in cycle N.
  - Request/grant in N+1.
  - rvalid in N+2.
  - inst_valid_o in N+3.
- Streaming: after warm-up, one instruction per cycle with 1-cycle memory latency and DEPTH ≥ 2.
- inst_ce_i=0: no request, no pop, no redirect; queue contents retained.
- rvalid with inflight=drop_cnt=0 is a protocol error: ignored, and flagged by a simulation-only assertion.

Test Plan:
- Reset, then rst=1, inst_addr_i=0, ack=1, memory returns mem[a]=a+32'h100 one cycle after grant → requests 0,4,8,…; inst_valid_o first high in cycle 3 with inst_o=32'h100, then one new word per cycle.
- Stall: ack=0 for 5 cycles with queue full → mem_req_o low after count=4, inst_o held at the same word; ack=1 resumes with no gaps and no duplicates.
- Redirect with 2 in flight (memory latency 3): inst_addr_i 8→32'h40 → queue emptied, the next 2 responses discarded; first valid word 32'h140 at address 32'h40; no stale word ever shown.
- Back-to-back redirects (0x40 then 0x80 one cycle later, before any returns) → drop_cnt accumulates, total outstanding ≤ 4; only 32'h180 appears first.
- Grant withheld (mem_gnt_i=0 for 4 cycles) → mem_req_o stays high with mem_addr_o stable; inst_valid_o=0.
- Async reset asserted mid-stream, between clock edges → all outputs 0 immediately; after release, fetch restarts at RESET_ADDR and stale responses are not enqueued (memory model also reset).

Source files
------------

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words ahead of the PC into a
// small FIFO, flushes on PC redirect and discards responses to stale requests.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr_i,
    input  logic        inst_ce_i,
    input  logic        inst_ack_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW+1:0] LP_DEPTH = (CW + 2)'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;
    logic [31:0]   r_head_addr;
    logic [31:0]   r_fetch_addr;

    logic          w_redirect;
    logic          w_hit;
    logic          w_grant;
    logic          w_pop;
    logic          w_rsp_any;
    logic          w_rsp_keep;
    logic          w_rsp_drop;
    logic [CW+1:0] w_total;

    assign w_redirect = inst_ce_i && (inst_addr_i != r_head_addr);
    assign w_hit      = inst_ce_i && !w_redirect && (r_count != '0);
    assign w_total    = {2'b00, r_count} + {2'b00, r_inflight} + {2'b00, r_drop};
    assign w_grant    = mem_req_o && mem_gnt_i;
    assign w_pop      = w_hit && inst_ack_i;

    // Older (dropped) requests always return before kept ones, so drops win.
    assign w_rsp_drop = mem_rvalid_i && (r_drop != '0);
    assign w_rsp_keep = mem_rvalid_i && (r_drop == '0) && (r_inflight != '0);
    assign w_rsp_any  = w_rsp_drop || w_rsp_keep;

    assign inst_valid_o = w_hit;
    assign inst_o       = w_hit ? r_mem[r_rd_ptr] : '0;
    assign mem_req_o    = rst && inst_ce_i && !w_redirect && (w_total < LP_DEPTH);
    assign mem_addr_o   = r_fetch_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_inflight   <= '0;
            r_drop       <= '0;
            r_head_addr  <= RESET_ADDR;
            r_fetch_addr <= RESET_ADDR;
        end else if (w_redirect) begin
            // Everything outstanding becomes a drop, minus the one returning now.
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_inflight   <= '0;
            r_drop       <= r_drop + r_inflight - CW'(w_rsp_any);
            r_head_addr  <= inst_addr_i;
            r_fetch_addr <= inst_addr_i;
        end else begin
            if (w_rsp_keep) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + PW'(1);
                r_head_addr <= r_head_addr + 32'd4;
            end
            if (w_grant) begin
                r_fetch_addr <= r_fetch_addr + 32'd4;
            end
            if (w_rsp_drop) begin
                r_drop <= r_drop - CW'(1);
            end
            r_count    <= r_count + CW'(w_rsp_keep) - CW'(w_pop);
            r_inflight <= r_inflight + CW'(w_grant) - CW'(w_rsp_keep);
        end
    end

    always_ff @(posedge clk) begin
        if (w_rsp_keep && !w_redirect) begin
            r_mem[r_wr_ptr] <= mem_rdata_i;
        end
    end

`ifndef SYNTHESIS
    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst)
        !(mem_rvalid_i && (r_inflight == '0) && (r_drop == '0)));
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: queue-level reference model, pipelined memory
// returning mem[a] = a + 0x100, and directed scenarios with literal expectations.
module tb_inst_prefetch_queue;

    localparam int          DEPTH      = 4;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr_i;
    logic        inst_ce_i;
    logic        inst_ack_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    always #5 clk = ~clk;

    inst_prefetch_queue #(
        .DEPTH      (DEPTH),
        .RESET_ADDR (RESET_ADDR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_addr_i  (inst_addr_i),
        .inst_ce_i    (inst_ce_i),
        .inst_ack_i   (inst_ack_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queued words, and one keep/drop tag per outstanding grant.
    logic [31:0] m_words[$];
    bit          m_tags[$];
    logic [31:0] m_head;
    logic [31:0] m_fetch;
    bit          m_pop;

    // Memory environment: in-order pipelined responses after 'lat' cycles.
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          cyc;
    int          lat;
    bit          nv;
    logic [31:0] nd;
    logic        s_req;
    logic [31:0] s_addr;

    function automatic bit f_red();
        return inst_ce_i && (inst_addr_i != m_head);
    endfunction

    function automatic bit f_hit();
        return rst && inst_ce_i && !f_red() && (m_words.size() != 0);
    endfunction

    function automatic bit f_req();
        return rst && inst_ce_i && !f_red() && ((m_words.size() + m_tags.size()) < DEPTH);
    endfunction

    task automatic model_reset();
        m_words.delete();
        m_tags.delete();
        m_head  = RESET_ADDR;
        m_fetch = RESET_ADDR;
        m_pop   = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        nv = 1'b0;
        nd = 32'hDEAD_BEEF;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'hDEAD_BEEF;
    endtask

    task automatic model_step();
        bit red, hit, req;
        red   = f_red();
        hit   = f_hit();
        req   = f_req();
        m_pop = hit && inst_ack_i;
        if (mem_rvalid_i && m_tags.size() != 0) begin
            bit k;
            k = m_tags.pop_front();
            if (k && !red) m_words.push_back(mem_rdata_i);
        end
        if (red) begin
            m_words.delete();
            foreach (m_tags[i]) m_tags[i] = 1'b0;
            m_head  = inst_addr_i;
            m_fetch = inst_addr_i;
        end else begin
            if (m_pop) begin
                void'(m_words.pop_front());
                m_head = m_head + 32'd4;
            end
            if (req && mem_gnt_i) begin
                m_tags.push_back(1'b1);
                m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    task automatic mem_step();
        if (s_req && mem_gnt_i) begin
            mq_addr.push_back(s_addr);
            mq_due.push_back(cyc + lat);
        end
        check("outstanding_le_depth", 32'(mq_addr.size() <= DEPTH), 32'd1);
        cyc++;
        if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            nv = 1'b1;
            nd = mq_addr.pop_front() + 32'h100;
            void'(mq_due.pop_front());
        end else begin
            nv = 1'b0;
            nd = 32'hDEAD_BEEF;
        end
    endtask

    // One clock: update model at the edge, drive new inputs just after it.
    task automatic tick();
        @(posedge clk);
        m_pop = 1'b0;
        if (rst) begin
            model_step();
            mem_step();
        end
        #1;
        mem_rvalid_i = nv;
        mem_rdata_i  = nd;
        if (m_pop) inst_addr_i = inst_addr_i + 32'd4;
    endtask

    always @(negedge clk) begin : cmp
        bit          hit;
        logic [31:0] ei;
        s_req  = mem_req_o;
        s_addr = mem_addr_o;
        hit = f_hit();
        ei  = hit ? m_words[0] : 32'h0;
        check("inst_valid_o", 32'(inst_valid_o), 32'(hit));
        check("inst_o", inst_o, ei);
        check("mem_req_o", 32'(mem_req_o), 32'(f_req()));
        check("mem_addr_o", mem_addr_o, m_fetch);
        if (hit) check("model_word_for_pc", ei, inst_addr_i + 32'h100);
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
        check({tag, "_inst"}, inst_o, 32'd0);
        check({tag, "_req"}, 32'(mem_req_o), 32'd0);
        check({tag, "_addr"}, mem_addr_o, RESET_ADDR);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        inst_ce_i   = 1'b1;
        inst_addr_i = RESET_ADDR;
        inst_ack_i  = 1'b1;
        mem_gnt_i   = 1'b1;
        lat = 1;
        #1;
        check_reset_outputs("reset");
        tick();
        tick();
        #2;
        rst = 1'b1;
    endtask

    task automatic run_until_valid(input int max, input string name, input logic [31:0] exp_inst);
        bit got;
        got = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (inst_valid_o === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check({name, "_seen"}, 32'(got), 32'd1);
        if (got) check(name, inst_o, exp_inst);
    endtask

    logic [31:0] held;

    initial begin
        cyc = 0;
        do_reset();

        // Warm-up from reset: valid first in cycle 3, then one word per cycle.
        @(negedge clk);
        check("c1_valid", 32'(inst_valid_o), 32'd0);
        check("c1_req", 32'(mem_req_o), 32'd1);
        check("c1_addr", mem_addr_o, 32'h0);
        tick();
        @(negedge clk);
        check("c2_valid", 32'(inst_valid_o), 32'd0);
        check("c2_addr", mem_addr_o, 32'h4);
        tick();
        @(negedge clk);
        check("c3_valid", 32'(inst_valid_o), 32'd1);
        check("c3_inst", inst_o, 32'h100);
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            check("stream_valid", 32'(inst_valid_o), 32'd1);
            check("stream_inst", inst_o, 32'(32'h104 + 4 * i));
        end

        // Fetch disabled: nothing valid, no requests, contents kept.
        tick();
        inst_ce_i = 1'b0;
        @(negedge clk);
        check("ce0_valid", 32'(inst_valid_o), 32'd0);
        check("ce0_req", 32'(mem_req_o), 32'd0);
        tick();
        @(negedge clk);
        check("ce0_req2", 32'(mem_req_o), 32'd0);
        tick();
        inst_ce_i = 1'b1;
        @(negedge clk);
        check("ce1_valid", 32'(inst_valid_o), 32'd1);
        check("ce1_inst", inst_o, inst_addr_i + 32'h100);

        // Stall: queue fills, requests stop, head word held.
        tick();
        inst_ack_i = 1'b0;
        held = inst_addr_i + 32'h100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_inst", inst_o, held);
            if (i >= 3) check("stall_req", 32'(mem_req_o), 32'd0);
            tick();
        end
        inst_ack_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("resume_valid", 32'(inst_valid_o), 32'd1);
            check("resume_inst", inst_o, held + 32'(4 * i));
            tick();
        end

        // Redirect to 0x40 at PC 8 with slow memory: stale words never shown.
        do_reset();
        lat = 3;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (inst_addr_i == 32'h8) break;
        end
        check("redir_at_pc8", inst_addr_i, 32'h8);
        inst_addr_i = 32'h40;
        @(negedge clk);
        check("redir_valid", 32'(inst_valid_o), 32'd0);
        check("redir_req", 32'(mem_req_o), 32'd0);
        tick();
        run_until_valid(20, "redir_first", 32'h140);

        // Back-to-back redirects before any response returns.
        tick();
        do_reset();
        lat = 3;
        tick();
        inst_addr_i = 32'h40;
        @(negedge clk);
        check("b2b_req1", 32'(mem_req_o), 32'd0);
        tick();
        inst_addr_i = 32'h80;
        @(negedge clk);
        check("b2b_req2", 32'(mem_req_o), 32'd0);
        tick();
        run_until_valid(20, "b2b_first", 32'h180);

        // Grant withheld: request and address held steady.
        tick();
        do_reset();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("nognt_req", 32'(mem_req_o), 32'd1);
            check("nognt_addr", mem_addr_o, 32'h0);
            check("nognt_valid", 32'(inst_valid_o), 32'd0);
            tick();
        end
        mem_gnt_i = 1'b1;
        run_until_valid(10, "gnt_first", 32'h100);

        // Asynchronous reset mid-stream, between edges.
        lat = 2;
        for (int i = 0; i < 6; i++) tick();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("async_rst");
        inst_addr_i = RESET_ADDR;
        tick();
        tick();
        #2;
        rst = 1'b1;
        run_until_valid(10, "rst_first", 32'h100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
